// File: rtl/dc_blocker_mc.sv
// rtl/dc_blocker_mc.sv - multi-channel decimated DC baseline estimator/subtractor (option: DC_BLOCKER_MC_SAT_EN saturates the difference)
module dc_blocker_mc #(
    parameter int CH       = 4,
    parameter int WIDTH    = 14,
    parameter int WIN_LOG2 = 10,
    parameter int SKIP_W   = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [SKIP_W-1:0]     skip,
    input  logic [CH*WIDTH-1:0]   data_in,
    input  logic [CH-1:0]         freeze,
    output logic [CH*WIDTH-1:0]   data_out,
    output logic                  out_valid,
    output logic [CH*WIDTH-1:0]   baseline_out,
    output logic [CH-1:0]         baseline_valid
);

    localparam int ACC_W = WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);
    localparam logic [SKIP_W-1:0]   SK_ONE   = SKIP_W'(1);

    logic signed [ACC_W-1:0] acc      [CH];
    logic [WIN_LOG2-1:0]     cnt      [CH];
    logic [WIDTH-1:0]        baseline [CH];
    logic [SKIP_W-1:0]       sk;

    logic signed [ACC_W-1:0] sum      [CH];
    logic [WIDTH-1:0]        diff     [CH];
    logic                    accept;

    assign accept = sample_en && (sk == '0);

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            logic [WIDTH-1:0] xs;
            xs     = data_in[c*WIDTH +: WIDTH];
            sum[c] = acc[c] + $signed({{WIN_LOG2{xs[WIDTH-1]}}, xs});
`ifdef DC_BLOCKER_MC_SAT_EN
            begin
                logic [WIDTH:0] d;
                d = {xs[WIDTH-1], xs} - {baseline[c][WIDTH-1], baseline[c]};
                // Top two bits disagree only when the difference left the WIDTH range.
                if (d[WIDTH] != d[WIDTH-1])
                    diff[c] = d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    diff[c] = d[WIDTH-1:0];
            end
`else
            diff[c] = xs - baseline[c];
`endif
        end
    end

    always_comb begin
        baseline_out = '0;
        for (int c = 0; c < CH; c++)
            baseline_out[c*WIDTH +: WIDTH] = baseline[c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sk             <= '0;
            out_valid      <= 1'b0;
            data_out       <= '0;
            baseline_valid <= '0;
            for (int c = 0; c < CH; c++) begin
                acc[c]      <= '0;
                cnt[c]      <= '0;
                baseline[c] <= '0;
            end
        end else begin
            out_valid <= sample_en;
            if (sample_en) begin
                sk <= (sk == '0) ? skip : sk - SK_ONE;
                for (int c = 0; c < CH; c++) begin
                    data_out[c*WIDTH +: WIDTH] <= diff[c];
                    // A frozen channel holds acc/cnt, stretching its window rather than shortening it.
                    if (accept && !freeze[c]) begin
                        if (cnt[c] == CNT_LAST) begin
                            baseline[c]       <= sum[c][ACC_W-1:WIN_LOG2];
                            acc[c]            <= '0;
                            cnt[c]            <= '0;
                            baseline_valid[c] <= 1'b1;
                        end else begin
                            acc[c] <= sum[c];
                            cnt[c] <= cnt[c] + CNT_ONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dc_blocker_mc.sv
// tb/tb_dc_blocker_mc.sv - randomized and directed check of dc_blocker_mc against a queue-based model
module tb_dc_blocker_mc;
    localparam int CH = 4, W = 14, WL = 4, SW = 30, N = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_en;
    logic [SW-1:0]     skip;
    logic [CH*W-1:0]   data_in;
    logic [CH-1:0]     freeze;
    logic [CH*W-1:0]   data_out;
    logic              out_valid;
    logic [CH*W-1:0]   baseline_out;
    logic [CH-1:0]     baseline_valid;

    dc_blocker_mc #(.CH(CH), .WIDTH(W), .WIN_LOG2(WL), .SKIP_W(SW)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .skip(skip),
        .data_in(data_in), .freeze(freeze), .data_out(data_out),
        .out_valid(out_valid), .baseline_out(baseline_out),
        .baseline_valid(baseline_valid)
    );

    always #5 clk = ~clk;

    int xin [CH];
    always_comb begin
        data_in = '0;
        for (int c = 0; c < CH; c++) data_in[c*W +: W] = xin[c][W-1:0];
    end

    int vectors = 0, miscompares = 0;
    bit chk_on = 0;

    int m_bl [CH];
    bit m_bv [CH];
    int m_q  [CH][$];
    int m_do [CH];
    bit m_ov;
    int m_skl;

    function automatic int sx(input logic [W-1:0] v);
        int r;
        r = $signed(v);
        return r;
    endfunction

    function automatic int floor_div(input int a, input int n);
        if (a >= 0) return a / n;
        return -((-a + n - 1) / n);
    endfunction

    function automatic int fit(input int d);
        int t;
`ifdef DC_BLOCKER_MC_SAT_EN
        if (d > 8191) return 8191;
        if (d < -8192) return -8192;
        return d;
`else
        t = d;
        return sx(t[W-1:0]);
`endif
    endfunction

    task automatic model_update();
        if (reset) begin
            m_ov = 0; m_skl = 0;
            for (int c = 0; c < CH; c++) begin
                m_bl[c] = 0; m_bv[c] = 0; m_do[c] = 0; m_q[c].delete();
            end
        end else begin
            m_ov = sample_en;
            if (sample_en) begin
                bit acc_ok;
                for (int c = 0; c < CH; c++) m_do[c] = fit(xin[c] - m_bl[c]);
                acc_ok = (m_skl == 0);
                m_skl = acc_ok ? int'(skip) : m_skl - 1;
                if (acc_ok) begin
                    for (int c = 0; c < CH; c++) begin
                        if (!freeze[c]) begin
                            m_q[c].push_back(xin[c]);
                            if (m_q[c].size() == N) begin
                                int s;
                                s = 0;
                                foreach (m_q[c][k]) s += m_q[c][k];
                                m_bl[c] = floor_div(s, N);
                                m_bv[c] = 1;
                                m_q[c].delete();
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dout(input int c);
        return sx(data_out[c*W +: W]);
    endfunction

    function automatic int blo(input int c);
        return sx(baseline_out[c*W +: W]);
    endfunction

    task automatic compare_all();
        if (!chk_on) return;
        check("model out_valid", int'(out_valid), int'(m_ov));
        for (int c = 0; c < CH; c++) begin
            check($sformatf("model baseline_valid[%0d]", c), int'(baseline_valid[c]), int'(m_bv[c]));
            check($sformatf("model baseline_out[%0d]", c), blo(c), m_bl[c]);
            check($sformatf("model data_out[%0d]", c), dout(c), m_do[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic strobe(input int n);
        sample_en = 1'b1;
        repeat (n) tick();
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_on = 1;
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < CH; c++) xin[c] = v;
    endtask

    initial begin
        int base;
        reset = 1'b1; sample_en = 1'b0; skip = '0; freeze = '0; set_all(0);
        do_reset();
        check("reset out_valid", int'(out_valid), 0);
        check("reset baseline_valid", int'(baseline_valid), 0);
        check("reset data_out ch0", dout(0), 0);

        // basic window
        set_all(100);
        strobe(15);
        check("basic pre out_valid", int'(out_valid), 1);
        check("basic pre data_out ch0", dout(0), 100);
        check("basic pre valid ch0", int'(baseline_valid[0]), 0);
        strobe(1);
        check("basic valid ch0", int'(baseline_valid[0]), 1);
        check("basic baseline ch0", blo(0), 100);
        tick();
        check("basic out_valid drops", int'(out_valid), 0);
        strobe(1);
        check("basic data_out ch0 after", dout(0), 0);

        // floor rounding
        do_reset();
        set_all(0); xin[1] = -3; strobe(8);
        xin[1] = -4; strobe(8);
        check("floor baseline ch1", blo(1), -4);
        xin[1] = -3; strobe(1);
        check("floor data_out ch1", dout(1), 1);

        // decimation
        do_reset();
        skip = 3; set_all(7);
        strobe(60);
        check("decim valid after 60", int'(baseline_valid[0]), 0);
        strobe(1);
        check("decim valid after 61", int'(baseline_valid[0]), 1);
        check("decim baseline ch0", blo(0), 7);
        skip = 0;

        // freeze
        do_reset();
        set_all(50);
        strobe(4);
        xin[2] = 1000; freeze = 4'b0100;
        strobe(8);
        xin[2] = 50; freeze = '0;
        strobe(4);
        check("freeze ch3 valid at 16", int'(baseline_valid[3]), 1);
        check("freeze ch2 not valid at 16", int'(baseline_valid[2]), 0);
        strobe(7);
        check("freeze ch2 not valid at 23", int'(baseline_valid[2]), 0);
        strobe(1);
        check("freeze ch2 valid at 24", int'(baseline_valid[2]), 1);
        check("freeze ch2 baseline", blo(2), 50);

        // saturation / wrap
        do_reset();
        set_all(0); xin[0] = -8000;
        strobe(16);
        check("sat baseline ch0", blo(0), -8000);
        xin[0] = 8191; strobe(1);
`ifdef DC_BLOCKER_MC_SAT_EN
        check("sat data_out ch0", dout(0), 8191);
`else
        check("wrap data_out ch0", dout(0), -193);
`endif

        // reset mid-window, reset wins over sample_en
        do_reset();
        set_all(500); strobe(10);
        reset = 1'b1; sample_en = 1'b1; tick();
        check("midrst during out_valid", int'(out_valid), 0);
        check("midrst during data_out", dout(0), 0);
        reset = 1'b0; sample_en = 1'b0; tick();
        check("midrst after out_valid", int'(out_valid), 0);
        check("midrst after baseline", blo(0), 0);
        check("midrst after valid", int'(baseline_valid), 0);
        set_all(20); strobe(16);
        check("midrst baseline ch0", blo(0), 20);
        check("midrst valid ch0", int'(baseline_valid[0]), 1);

        // randomized traffic
        do_reset();
        base = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) base = int'($urandom_range(0, 14000)) - 7000;
            if ($urandom_range(0, 63) == 0) skip = SW'($urandom_range(0, 3));
            sample_en = ($urandom_range(0, 9) < 7);
            freeze = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                int v;
                if ($urandom_range(0, 15) == 0) v = int'($urandom_range(0, 16383)) - 8192;
                else v = base + int'($urandom_range(0, 3000)) - 1500;
                if (v > 8191) v = 8191;
                if (v < -8192) v = -8192;
                xin[c] = v;
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; sample_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
